// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the control unit and the fetch-stage blocks.
// Contents:
//   PC_W      - default program-counter width
//   pc_t      - program-counter type at the default width
//   FUNC_JSB  - func encoding of jump-to-subroutine (drives return_stack push)
//   FUNC_RET  - func encoding of return (drives return_stack pop)
package cpu_pkg;

  localparam int PC_W = 12;

  typedef logic [PC_W-1:0] pc_t;

  localparam logic [4:0] FUNC_JSB = 5'b11101;
  localparam logic [4:0] FUNC_RET = 5'b11110;

endpackage

// File: rtl/stack_mem.sv
// Register array holding the return addresses.
// Ports:
//   clk   - rising-edge clock
//   we    - write enable
//   waddr - write slot
//   wdata - write data
//   raddr - read slot (combinational read)
//   rdata - contents of slot raddr
// Contents are deliberately not reset; the owner masks reads while empty.
module stack_mem #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 12
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [ADDR_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [ADDR_W-1:0]        rdata
);

  logic [ADDR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack.sv
// Subroutine-return stack beside the PC register. JSB pushes the return PC,
// RET pops it; the top entry is presented combinationally so RET can use it
// in the same cycle it pops.
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-low reset
//   push      - store push_addr as new top
//   pop       - discard current top
//   push_addr - return address to store
//   clr_err   - synchronous clear of the sticky flags (a same-cycle set wins)
//   top_addr  - current top entry, 0 when empty
//   count     - number of valid entries
//   empty     - count == 0
//   full      - count == DEPTH
//   overflow  - sticky: a push was dropped while full
//   underflow - sticky: a pop arrived while empty
module return_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = PC_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic                       clr_err,
  output logic [ADDR_W-1:0]          top_addr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int SP_W  = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [SP_W-1:0]  SP_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_dec;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_empty;
  logic              is_full;
  logic              we;
  logic [SP_W-1:0]   waddr;
  logic              do_inc;
  logic              do_dec;
  logic              set_ovf;
  logic              set_unf;
  logic [ADDR_W-1:0] rdata;

  assign sp_dec   = sp - SP_ONE;
  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CNT_MAX);

  // Push+pop on a non-empty stack is a replace of the top slot; on an empty
  // stack it degrades to a plain push.
  always_comb begin
    we      = 1'b0;
    waddr   = sp;
    do_inc  = 1'b0;
    do_dec  = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (push && pop && !is_empty) begin
      we    = 1'b1;
      waddr = sp_dec;
    end else if (push) begin
      if (is_full) begin
        set_ovf = 1'b1;
      end else begin
        we     = 1'b1;
        do_inc = 1'b1;
      end
    end else if (pop) begin
      if (is_empty) set_unf = 1'b1;
      else          do_dec  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp        <= '0;
      cnt_q     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_inc) begin
        sp    <= sp + SP_ONE;
        cnt_q <= cnt_q + CNT_ONE;
      end else if (do_dec) begin
        sp    <= sp_dec;
        cnt_q <= cnt_q - CNT_ONE;
      end
      if (set_ovf)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (set_unf)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  stack_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (push_addr),
    .raddr (sp_dec),
    .rdata (rdata)
  );

  assign top_addr = is_empty ? '0 : rdata;
  assign count    = cnt_q;
  assign empty    = is_empty;
  assign full     = is_full;

endmodule

// File: tb/tb_return_stack.sv
// Bench for return_stack at DEPTH=4, ADDR_W=12. A driver applies one command
// per cycle and queues the outputs expected during that cycle from a queue-based
// model of the stack; a monitor pops and compares them before the next edge.
module tb_return_stack;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 12;
  localparam int CW     = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic              clr_err = 1'b0;
  logic [ADDR_W-1:0] push_addr = '0;
  logic [ADDR_W-1:0] top_addr;
  logic [CW-1:0]     count;
  logic              empty, full, overflow, underflow;

  return_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_addr (push_addr),
    .clr_err   (clr_err),
    .top_addr  (top_addr),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] top;
    logic [CW-1:0]     cnt;
    logic              emp;
    logic              ful;
    logic              ovf;
    logic              unf;
  } obs_t;

  obs_t              exp_q[$];
  logic [ADDR_W-1:0] model[$];
  bit                m_ovf = 1'b0;
  bit                m_unf = 1'b0;
  int                checks = 0;
  int                passed = 0;

  function automatic obs_t model_obs();
    obs_t o;
    o.top = (model.size() > 0) ? model[model.size()-1] : '0;
    o.cnt = CW'(model.size());
    o.emp = (model.size() == 0);
    o.ful = (model.size() == DEPTH);
    o.ovf = m_ovf;
    o.unf = m_unf;
    return o;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One command per cycle, applied in the low phase. Outputs expected in this
  // cycle reflect all earlier edges (or an immediate asynchronous reset).
  task automatic step(input bit p, input bit po, input logic [ADDR_W-1:0] a,
                      input bit c, input bit r);
    bit so, su;
    @(negedge clk);
    push = p; pop = po; push_addr = a; clr_err = c; rst = r;
    if (!r) begin
      model.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    exp_q.push_back(model_obs());
    if (r) begin
      so = 1'b0;
      su = 1'b0;
      if (p && po && model.size() > 0) model[model.size()-1] = a;
      else if (p) begin
        if (model.size() == DEPTH) so = 1'b1;
        else model.push_back(a);
      end else if (po) begin
        if (model.size() == 0) su = 1'b1;
        else void'(model.pop_back());
      end
      m_ovf = so || (m_ovf && !c);
      m_unf = su || (m_unf && !c);
    end
  endtask

  always @(negedge clk) begin
    obs_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("top_addr",  int'(top_addr),  int'(e.top));
      check("count",     int'(count),     int'(e.cnt));
      check("empty",     int'(empty),     int'(e.emp));
      check("full",      int'(full),      int'(e.ful));
      check("overflow",  int'(overflow),  int'(e.ovf));
      check("underflow", int'(underflow), int'(e.unf));
    end
  end

  initial begin
    // 1: reset then idle
    step(0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 1);
    // 2: push three, pop three
    step(1, 0, 12'h010, 0, 1);
    step(1, 0, 12'h020, 0, 1);
    step(1, 0, 12'h030, 0, 1);
    repeat (3) step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // 3: overflow, then clear
    for (int i = 0; i < 5; i++) step(1, 0, 12'h100 + 12'(i), 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    // 4: drain, underflow, then push with clear in the same cycle
    repeat (4) step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 12'h0AA, 1, 1);
    step(0, 0, 0, 0, 1);
    // 5: replace top, and push+pop on empty
    step(0, 1, 0, 0, 1);
    step(1, 0, 12'h011, 0, 1);
    step(1, 1, 12'h022, 0, 1);
    step(0, 1, 0, 1, 1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    step(1, 1, 12'h033, 0, 1);
    step(0, 0, 0, 0, 1);
    // replace while full
    for (int i = 0; i < 3; i++) step(1, 0, 12'h200 + 12'(i), 0, 1);
    step(1, 1, 12'h2FF, 0, 1);
    step(0, 1, 0, 0, 1);
    // 6: asynchronous reset mid-operation, then push after release
    step(1, 0, 12'h011, 0, 1);
    step(1, 0, 12'h022, 0, 1);
    step(1, 0, 12'h0EE, 0, 0);
    step(1, 0, 12'h055, 0, 1);
    step(0, 0, 0, 0, 1);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit p, po, c, r;
      p  = ($urandom_range(0, 1) == 1);
      po = ($urandom_range(0, 2) == 0);
      c  = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 99) != 0);
      step(p, po, 12'($urandom), c, r);
    end
    step(0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    #4;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
